nrzi_unstuff: RTL

NRZI_UNSTUFF -- requirements
Module: nrzi_unstuff

---
 rtl/nrzi_unstuff.sv | 122 ++++++++++++
 1 files changed

// File: rtl/nrzi_unstuff.sv
// NRZI decoder with bit-unstuffing and SE0-based end-of-packet detection.
// All outputs are registered; the response to a strobe appears one cycle later.
//
// state | meaning
// RUN   | decoding and unstuffing data bits
// ERR   | error seen; discard bits until SE0, SE0, J
// SE0_1 | one SE0 bit time seen
// SE0_2 | two SE0 bit times seen; J completes end-of-packet
module nrzi_unstuff #(
  parameter int MAX_ONES = 6
) (
  input  logic clk,
  input  logic rst_L,
  input  logic inb,
  input  logic inb_valid,
  input  logic se0,
  output logic outb,
  output logic outb_valid,
  output logic stuff_err,
  output logic eop,
  output logic eop_err
);

  localparam int OW = $clog2(MAX_ONES + 1);
  localparam logic [OW-1:0] MAX_CNT = OW'(MAX_ONES);
  localparam logic [OW-1:0] ONE_CNT = OW'(1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    ERR   = 2'd1,
    SE0_1 = 2'd2,
    SE0_2 = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          prev_lvl, prev_lvl_nxt;
  logic [OW-1:0] ones, ones_nxt;
  logic          outb_nxt, outb_valid_nxt, stuff_err_nxt, eop_nxt, eop_err_nxt;
  logic          dec_bit;

  assign dec_bit = (inb == prev_lvl);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state      <= RUN;
      prev_lvl   <= 1'b1;
      ones       <= '0;
      outb       <= 1'b0;
      outb_valid <= 1'b0;
      stuff_err  <= 1'b0;
      eop        <= 1'b0;
      eop_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      prev_lvl   <= prev_lvl_nxt;
      ones       <= ones_nxt;
      outb       <= outb_nxt;
      outb_valid <= outb_valid_nxt;
      stuff_err  <= stuff_err_nxt;
      eop        <= eop_nxt;
      eop_err    <= eop_err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    prev_lvl_nxt   = prev_lvl;
    ones_nxt       = ones;
    outb_nxt       = outb;
    outb_valid_nxt = 1'b0;
    stuff_err_nxt  = 1'b0;
    eop_nxt        = 1'b0;
    eop_err_nxt    = 1'b0;
    if (inb_valid) begin
      case (state)
        RUN: begin
          if (se0) begin
            state_nxt = SE0_1;
          end else begin
            prev_lvl_nxt = inb;
            if (ones < MAX_CNT) begin
              outb_nxt       = dec_bit;
              outb_valid_nxt = 1'b1;
              ones_nxt       = dec_bit ? ones + ONE_CNT : '0;
            end else if (!dec_bit) begin
              // stuffed zero: consumed silently
              ones_nxt = '0;
            end else begin
              stuff_err_nxt = 1'b1;
              state_nxt     = ERR;
            end
          end
        end
        ERR: begin
          if (se0) state_nxt = SE0_1;
          else     prev_lvl_nxt = inb;
        end
        SE0_1: begin
          if (se0) begin
            state_nxt = SE0_2;
          end else begin
            eop_err_nxt = 1'b1;
            state_nxt   = ERR;
          end
        end
        SE0_2: begin
          if (!se0 && inb) begin
            eop_nxt      = 1'b1;
            prev_lvl_nxt = 1'b1;
            ones_nxt     = '0;
            state_nxt    = RUN;
          end else begin
            eop_err_nxt = 1'b1;
            state_nxt   = ERR;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

endmodule
